// File: rtl/counter_if.sv
// counter_if: groups the increment request and the count result of one counter.
interface counter_if #(
  parameter int WIDTH = 8
);
  logic             inc;
  logic [WIDTH-1:0] count;

  modport master (output inc, input  count);
  modport slave  (input  inc, output count);
endinterface

// File: rtl/counter.sv
// counter: synchronised, rise-triggered increment counter with modulo-2^WIDTH wrap.
// Optional debounce filter between synchroniser and edge detector: define COUNTER_DEBOUNCE_EN.
module counter #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  if (SYNC_STAGES < 32'sd2 || SYNC_STAGES > 32'sd4 ||
      DEBOUNCE_CYCLES < 32'sd1 || DEBOUNCE_CYCLES > 32'sd255) begin : g_param_check
    $error("counter: parameter out of legal range");
  end

  localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   level_sync;
  logic                   level;
  logic                   prev_q;
  logic                   prev_d;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       count_d;

  // inc is only ever read by the first synchroniser flop
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], inc};
  end

  assign level_sync = sync_q[SYNC_STAGES-1];

`ifdef COUNTER_DEBOUNCE_EN
  localparam logic [7:0] RUN_LAST = 8'(DEBOUNCE_CYCLES - 32'sd1);

  logic       filt_q;
  logic       filt_d;
  logic [7:0] run_q;
  logic [7:0] run_d;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    filt_d = filt_q;
    run_d  = 8'd0;
    if (level_sync != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_d = level_sync;
        run_d  = 8'd0;
      end else begin
        run_d  = run_q + 8'd1;
      end
    end else begin
      run_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      filt_q <= 1'b0;
      run_q  <= 8'd0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign level = filt_q;
`else
  assign level = level_sync;
`endif

  always_comb begin
    prev_d  = level;
    count_d = count_q;
    if (level && !prev_q) begin
      count_d = count_q + COUNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Reset has priority over a rise detected in the same cycle
  always_ff @(posedge clk) begin
    if (resetn) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      prev_q  <= 1'b0;
      count_q <= {WIDTH{1'b0}};
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed vector table plus hand-written toggle, wrap and debounce sequences.
module tb_counter;

`ifdef COUNTER_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam int PH  = 6;
`else
  localparam int LAT = 3;
  localparam int PH  = 2;
`endif

  typedef struct packed {
    logic       rst;
    logic       inc;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  counter_if #(.WIDTH(8)) bus ();

  counter #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inc    (bus.inc),
    .count  (bus.count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: count=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Inputs are driven at the falling edge, consumed at the next rising edge, sampled at the following falling edge
  task automatic cyc(input logic r, input logic i);
    resetn  = r;
    bus.inc = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t       vecs [35];
  logic [7:0] model;

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b1;
    bus.inc  = 1'b0;
    @(negedge clk);

`ifndef COUNTER_DEBOUNCE_EN
    // reset held with inc toggling
    vecs[0]  = '{1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 8'd0};
    // first rise: count changes on the third edge
    vecs[5]  = '{1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 8'd1};
    // minimum 2-high pulse
    vecs[12] = '{1'b0, 1'b1, 8'd1};
    vecs[13] = '{1'b0, 1'b1, 8'd1};
    vecs[14] = '{1'b0, 1'b0, 8'd2};
    vecs[15] = '{1'b0, 1'b0, 8'd2};
    // steady high then fall: single increment only
    vecs[16] = '{1'b0, 1'b1, 8'd2};
    vecs[17] = '{1'b0, 1'b1, 8'd2};
    vecs[18] = '{1'b0, 1'b1, 8'd3};
    vecs[19] = '{1'b0, 1'b1, 8'd3};
    vecs[20] = '{1'b0, 1'b0, 8'd3};
    vecs[21] = '{1'b0, 1'b0, 8'd3};
    vecs[22] = '{1'b0, 1'b0, 8'd3};
    // reset lands in the cycle the rise is detected
    vecs[23] = '{1'b0, 1'b1, 8'd3};
    vecs[24] = '{1'b0, 1'b1, 8'd3};
    vecs[25] = '{1'b1, 1'b0, 8'd0};
    vecs[26] = '{1'b0, 1'b0, 8'd0};
    vecs[27] = '{1'b0, 1'b0, 8'd0};
    vecs[28] = '{1'b0, 1'b0, 8'd0};
    // inc already high when reset is released
    vecs[29] = '{1'b1, 1'b1, 8'd0};
    vecs[30] = '{1'b0, 1'b1, 8'd0};
    vecs[31] = '{1'b0, 1'b1, 8'd0};
    vecs[32] = '{1'b0, 1'b1, 8'd1};
    vecs[33] = '{1'b0, 1'b1, 8'd1};
    vecs[34] = '{1'b0, 1'b1, 8'd1};

    for (int i = 0; i < 35; i++) begin
      cyc(vecs[i].rst, vecs[i].inc);
      check($sformatf("vec%0d", i), bus.count, vecs[i].exp);
    end
`else
    // 3-cycle glitch is filtered out
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("db_reset", bus.count, 8'd0);
    for (int e = 0; e < 3; e++) cyc(1'b0, 1'b1);
    for (int e = 0; e < 12; e++) begin
      cyc(1'b0, 1'b0);
      check("db_glitch", bus.count, 8'd0);
    end
    // clean 10-cycle pulse: +1 on the 7th edge after inc rises
    for (int e = 1; e <= 10; e++) begin
      cyc(1'b0, 1'b1);
      check($sformatf("db_pulse_e%0d", e), bus.count, (e >= 7) ? 8'd1 : 8'd0);
    end
    for (int e = 0; e < 12; e++) begin
      cyc(1'b0, 1'b0);
      check("db_after", bus.count, 8'd1);
    end
`endif

    // slow toggle: one increment per rise, LAT edges after it, none on falls
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    model = 8'd0;
    check("toggle_reset", bus.count, model);
    for (int k = 0; k < 4; k++) begin
      for (int e = 1; e <= 25; e++) begin
        cyc(1'b0, 1'b1);
        check($sformatf("toggle_rise%0d_e%0d", k, e), bus.count,
              (e >= LAT) ? model + 8'd1 : model);
      end
      model = model + 8'd1;
      for (int e = 1; e <= 25; e++) begin
        cyc(1'b0, 1'b0);
        check($sformatf("toggle_fall%0d_e%0d", k, e), bus.count, model);
      end
    end

    // 256 clean pulses from reset: 255 after pulse 255, wraps to 0 on pulse 256
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("wrap_reset", bus.count, 8'd0);
    for (int p = 1; p <= 256; p++) begin
      for (int e = 0; e < PH; e++) cyc(1'b0, 1'b1);
      for (int e = 0; e < PH; e++) cyc(1'b0, 1'b0);
      check($sformatf("wrap_p%0d", p), bus.count, 8'(p));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
